multi_debouncer: RTL and testbench
==================================

Name: multi_debouncer

Overview:
- Multi-channel, parametrised debouncer for board switches, push-buttons and slow status lines.
- Each channel is synchronised, then filtered by a run-time programmable stability count.
- Output is a glitch-free level per channel plus single-cycle rise and fall strobes.
- Sits between raw pad inputs and control logic such as reset sequencers and mode selects, replacing per-signal single-bit debouncers.

Parameters:
NUM_CH, 4, number of independent channels.
COUNT_WIDTH, 16, width of the stability counter and of stable_cnt.
SYNC_STAGES, 2, synchroniser flops per channel; legal range 2..4.
RESET_VAL, 0, reset level of synchroniser flops and sw_stat. It is 1 bit and applies to all channels.

Ports:
aclk  input  1  system clock.
aresetn  input  1  asynchronous active-low reset.
sw_in  input  NUM_CH  raw asynchronous inputs, one bit per channel.
stable_cnt  input  COUNT_WIDTH  cycles a new level must persist after synchronisation; quasi-static.
sw_stat  output  NUM_CH  debounced level per channel, registered.
rise_pulse  output  NUM_CH  one-cycle strobe when sw_stat[i] goes 0->1.
fall_pulse  output  NUM_CH  one-cycle strobe when sw_stat[i] goes 1->0.
any_change  output  1  registered OR of all rise and fall strobes, same cycle as the strobes.

Behaviour:
- Reset (aresetn low, asynchronous, no clock needed):
  - synchroniser flops and sw_stat = {NUM_CH{RESET_VAL}}.
  - all counters = 0.
  - rise_pulse, fall_pulse, any_change = 0.
  - No strobe is generated on reset release.
- Synchroniser: SYNC_STAGES-deep flop chain per channel. sync[i] is the last stage.
- Effective threshold: N = (stable_cnt == 0) ? 1 : stable_cnt.
- Per-channel counter cnt[i], updated each aclk edge:
  - sync[i] == sw_stat[i]: cnt <= 0, no update.
  - sync[i] != sw_stat[i] and cnt >= N-1: sw_stat[i] <= sync[i], cnt <= 0, strobe asserted on the same edge.
  - otherwise: cnt <= cnt+1.
  - Compare is >=, so lowering stable_cnt mid-count completes the transition on the next mismatching edge. cnt never wraps.
- Latency: input stable before edge E0 updates sw_stat on edge E(SYNC_STAGES+N-1). With SYNC_STAGES=2 and N=5, that is edge E6.
- Any return of sync[i] to sw_stat[i] before the threshold clears cnt[i]. Pulses shorter than N cycles after synchronisation are fully rejected.
- Strobes:
  - rise_pulse[i] = 1 for exactly one cycle when sw_stat[i] takes 1; fall_pulse[i] likewise for 0.
  - rise_pulse[i] and fall_pulse[i] are never both high.
  - Strobes are driven from the same flops as the sw_stat update (zero lag to sw_stat).
- Channels are fully independent. Simultaneous transitions on several channels each produce their own strobe; any_change is high once for that cycle.
- Back-to-back transitions: the earliest possible opposite transition is N cycles after the previous one. Strobes therefore never merge when N >= 1.
- Reset asserted mid-count discards the count. After release, counting restarts from 0 against RESET_VAL.

Test Plan (NUM_CH=4, COUNT_WIDTH=8, SYNC_STAGES=2, RESET_VAL=0, stable_cnt=5 unless noted):
1. Assert aresetn=0 with no clock edge, sw_in=4'hF -> sw_stat=0, all strobes=0 immediately. Release with sw_in=0 -> no strobe ever.
2. sw_in[0] 0->1 before E0, held -> sw_stat[0]=1 after E6; rise_pulse[0] and any_change high only for the cycle after E6; other channels unchanged.
3. sw_in[1] high for 4 cycles, then low -> sw_stat[1] stays 0, no strobes. Repeat with 5 cycles -> rise_pulse[1] once, then fall_pulse[1] exactly 5 cycles later.
4. sw_in[2] toggles every 2 cycles for 12 cycles, then stays high -> exactly one rise_pulse[2], 6 edges after the last input edge; zero fall_pulse[2].
5. stable_cnt=0 -> step on sw_in[3] reflected after E2. Change stable_cnt 200->3 while cnt[3]=10 mismatching -> sw_stat[3] updates on the next edge.
6. Channels 0 and 2 step simultaneously -> rise_pulse=4'b0101 in one cycle, any_change high for exactly one cycle. Assert reset at cnt=3 mid-count -> no strobe; after release, a full 5-cycle count is required.

Source files
------------

// File: rtl/multi_debouncer.sv
// Multi-channel switch debouncer: per-channel synchroniser, programmable stability
// filter, registered level plus single-cycle rise/fall strobes.
module multi_debouncer #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned COUNT_WIDTH = 16,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic [NUM_CH-1:0]      sw_in,
    input  logic [COUNT_WIDTH-1:0] stable_cnt,
    output logic [NUM_CH-1:0]      sw_stat,
    output logic [NUM_CH-1:0]      rise_pulse,
    output logic [NUM_CH-1:0]      fall_pulse,
    output logic                   any_change
);

    logic [SYNC_STAGES-1:0][NUM_CH-1:0]  sync_q, sync_d;
    logic [NUM_CH-1:0][COUNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [NUM_CH-1:0]                   stat_q, stat_d;
    logic [NUM_CH-1:0]                   rise_q, rise_d;
    logic [NUM_CH-1:0]                   fall_q, fall_d;
    logic                                any_q, any_d;
    logic [COUNT_WIDTH-1:0]              thr_m1;

    // Threshold minus one; a programmed zero behaves as a threshold of one.
    always_comb begin
        thr_m1 = '0;
        if (stable_cnt != '0) begin
            thr_m1 = stable_cnt - COUNT_WIDTH'(1);
        end
    end

    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = sw_in;
        for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
    end

    // Compare is >= so a lowered threshold completes a pending transition at once.
    always_comb begin
        stat_d = stat_q;
        cnt_d  = cnt_q;
        rise_d = '0;
        fall_d = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (sync_q[SYNC_STAGES-1][i] == stat_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] >= thr_m1) begin
                stat_d[i] = sync_q[SYNC_STAGES-1][i];
                cnt_d[i]  = '0;
                rise_d[i] = sync_q[SYNC_STAGES-1][i];
                fall_d[i] = ~sync_q[SYNC_STAGES-1][i];
            end else begin
                cnt_d[i] = cnt_q[i] + COUNT_WIDTH'(1);
            end
        end
        any_d = |(rise_d | fall_d);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sync_q <= {(SYNC_STAGES*NUM_CH){RESET_VAL}};
            stat_q <= {NUM_CH{RESET_VAL}};
            cnt_q  <= '0;
            rise_q <= '0;
            fall_q <= '0;
            any_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            stat_q <= stat_d;
            cnt_q  <= cnt_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            any_q  <= any_d;
        end
    end

    assign sw_stat    = stat_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign any_change = any_q;

endmodule

// File: tb/tb_multi_debouncer.sv
// Bench for multi_debouncer: directed vector table, hand-written corner sequences,
// and randomized stimulus against a history-window reference model.
module tb_multi_debouncer;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned CW     = 8;
    localparam int unsigned SS     = 2;
    localparam logic        RV     = 1'b0;

    logic              aclk;
    logic              aresetn;
    logic [NUM_CH-1:0] sw_in;
    logic [CW-1:0]     stable_cnt;
    logic [NUM_CH-1:0] sw_stat;
    logic [NUM_CH-1:0] rise_pulse;
    logic [NUM_CH-1:0] fall_pulse;
    logic              any_change;

    multi_debouncer #(
        .NUM_CH(NUM_CH), .COUNT_WIDTH(CW), .SYNC_STAGES(SS), .RESET_VAL(RV)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .sw_in(sw_in), .stable_cnt(stable_cnt),
        .sw_stat(sw_stat), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
        .any_change(any_change)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int checks   = 0;
    int failures = 0;
    int rise_acc = 0;
    int fall_acc = 0;

    // Reference model: a level flips once the last N synchronised samples all
    // disagree with it and none of them predates the previous flip or a reset.
    logic [NUM_CH-1:0] inq[$];
    logic [NUM_CH-1:0] synq[$];
    int                age[NUM_CH];
    logic [NUM_CH-1:0] m_stat, m_rise, m_fall;
    logic              m_any;

    task automatic model_reset();
        inq.delete();
        synq.delete();
        for (int s = 0; s < int'(SS); s++) inq.push_front({NUM_CH{RV}});
        for (int c = 0; c < int'(NUM_CH); c++) age[c] = 0;
        m_stat = {NUM_CH{RV}};
        m_rise = '0;
        m_fall = '0;
        m_any  = 1'b0;
    endtask

    task automatic model_edge(input logic [NUM_CH-1:0] sw, input logic [CW-1:0] sc);
        int n;
        logic [NUM_CH-1:0] s, prev;
        logic ok;
        n = (sc == 0) ? 1 : int'(sc);
        s = inq[SS-1];
        inq.push_front(sw);
        if (inq.size() > int'(SS)) void'(inq.pop_back());
        synq.push_front(s);
        if (synq.size() > 256) void'(synq.pop_back());
        prev = m_stat;
        for (int c = 0; c < int'(NUM_CH); c++) begin
            age[c]++;
            ok = (age[c] >= n);
            for (int j = 0; j < n && ok; j++) begin
                if (synq[j][c] == prev[c]) ok = 1'b0;
            end
            if (ok) begin
                m_stat[c] = ~prev[c];
                age[c]    = 0;
            end
        end
        m_rise = m_stat & ~prev;
        m_fall = ~m_stat & prev;
        m_any  = |(m_rise | m_fall);
    endtask

    task automatic check_model();
        checks++;
        if ({sw_stat, rise_pulse, fall_pulse, any_change} !== {m_stat, m_rise, m_fall, m_any}) begin
            failures++;
            $display("FAIL model t=%0t stat=%b/%b rise=%b/%b fall=%b/%b any=%b/%b (actual/required)",
                     $time, sw_stat, m_stat, rise_pulse, m_rise, fall_pulse, m_fall, any_change, m_any);
        end
        checks++;
        if ((rise_pulse & fall_pulse) != '0) begin
            failures++;
            $display("FAIL rise_fall_exclusive t=%0t rise=%b fall=%b required no overlap",
                     $time, rise_pulse, fall_pulse);
        end
    endtask

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    task automatic step(input int k);
        repeat (k) begin
            @(posedge aclk);
            model_edge(sw_in, stable_cnt);
            #1;
            check_model();
            rise_acc += $countones(rise_pulse);
            fall_acc += $countones(fall_pulse);
        end
    endtask

    // Reset pulse placed between clock edges, so no edge sees it.
    task automatic async_reset();
        #2;
        aresetn = 1'b0;
        #1;
        model_reset();
        check_eq("reset_outputs", 32'({sw_stat, rise_pulse, fall_pulse, any_change}), 32'h0);
        #2;
        aresetn = 1'b1;
    endtask

    typedef struct {
        logic [NUM_CH-1:0] sw;
        int                cyc;
        logic [NUM_CH-1:0] exp_stat;
        int                exp_rise;
        int                exp_fall;
    } vec_t;

    vec_t tbl[17];

    initial begin
        tbl[0]  = '{4'b0001, 6, 4'b0000, 0, 0};
        tbl[1]  = '{4'b0001, 1, 4'b0001, 1, 0};
        tbl[2]  = '{4'b0011, 4, 4'b0001, 0, 0};
        tbl[3]  = '{4'b0001, 8, 4'b0001, 0, 0};
        tbl[4]  = '{4'b0011, 5, 4'b0001, 0, 0};
        tbl[5]  = '{4'b0001, 2, 4'b0011, 1, 0};
        tbl[6]  = '{4'b0001, 4, 4'b0011, 0, 0};
        tbl[7]  = '{4'b0001, 1, 4'b0001, 0, 1};
        tbl[8]  = '{4'b0001, 6, 4'b0001, 0, 0};
        tbl[9]  = '{4'b0101, 2, 4'b0001, 0, 0};
        tbl[10] = '{4'b0001, 2, 4'b0001, 0, 0};
        tbl[11] = '{4'b0101, 2, 4'b0001, 0, 0};
        tbl[12] = '{4'b0001, 2, 4'b0001, 0, 0};
        tbl[13] = '{4'b0101, 2, 4'b0001, 0, 0};
        tbl[14] = '{4'b0001, 2, 4'b0001, 0, 0};
        tbl[15] = '{4'b0101, 6, 4'b0001, 0, 0};
        tbl[16] = '{4'b0101, 1, 4'b0101, 1, 0};

        // Reset applied before any clock edge, inputs all high.
        aresetn    = 1'b0;
        sw_in      = 4'hF;
        stable_cnt = CW'(5);
        model_reset();
        #2;
        check_eq("reset_no_clock", 32'({sw_stat, rise_pulse, fall_pulse, any_change}), 32'h0);
        @(negedge aclk);
        sw_in   = 4'h0;
        aresetn = 1'b1;
        rise_acc = 0; fall_acc = 0;
        step(20);
        check_eq("release_no_strobe", 32'(rise_acc + fall_acc), 32'd0);

        // Directed vector table.
        for (int r = 0; r < 17; r++) begin
            sw_in = tbl[r].sw;
            rise_acc = 0; fall_acc = 0;
            step(tbl[r].cyc);
            check_eq($sformatf("tbl%0d_stat", r), 32'(sw_stat), 32'(tbl[r].exp_stat));
            check_eq($sformatf("tbl%0d_rises", r), 32'(rise_acc), 32'(tbl[r].exp_rise));
            check_eq($sformatf("tbl%0d_falls", r), 32'(fall_acc), 32'(tbl[r].exp_fall));
        end

        // Zero threshold behaves as one: two sync stages then the update.
        stable_cnt = CW'(0);
        sw_in = 4'b1101;
        step(2);
        check_eq("n0_before", 32'(sw_stat), 32'h5);
        step(1);
        check_eq("n0_stat", 32'(sw_stat), 32'hD);
        check_eq("n0_rise", 32'(rise_pulse), 32'h8);

        // Lowering the threshold mid-count completes on the next edge.
        stable_cnt = CW'(200);
        sw_in = 4'b0101;
        step(12);
        check_eq("lower_pending", 32'(sw_stat), 32'hD);
        stable_cnt = CW'(3);
        step(1);
        check_eq("lower_stat", 32'(sw_stat), 32'h5);
        check_eq("lower_fall", 32'(fall_pulse), 32'h8);

        // Simultaneous rises on channels 0 and 2.
        stable_cnt = CW'(5);
        sw_in = 4'b0000;
        async_reset();
        sw_in = 4'b0101;
        step(6);
        check_eq("simul_before", 32'(sw_stat), 32'h0);
        step(1);
        check_eq("simul_rise", 32'(rise_pulse), 32'h5);
        check_eq("simul_any", 32'(any_change), 32'h1);
        step(1);
        check_eq("simul_rise_gone", 32'(rise_pulse), 32'h0);
        check_eq("simul_any_gone", 32'(any_change), 32'h0);

        // Reset mid-count discards progress; a full count is needed afterwards.
        async_reset();
        sw_in = 4'b0010;
        step(5);
        async_reset();
        rise_acc = 0; fall_acc = 0;
        step(6);
        check_eq("midreset_hold", 32'(sw_stat), 32'h0);
        check_eq("midreset_no_strobe", 32'(rise_acc + fall_acc), 32'd0);
        step(1);
        check_eq("midreset_stat", 32'(sw_stat), 32'h2);

        // Randomized phase against the model.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 300 == 0) stable_cnt = CW'($urandom_range(0, 6));
            if ($urandom_range(0, 199) == 0) async_reset();
            for (int c = 0; c < int'(NUM_CH); c++) begin
                if ($urandom_range(0, 7) == 0) sw_in[c] = ~sw_in[c];
            end
            step(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
